ir_bus_scheduler: RTL and testbench
===================================

# ir_bus_scheduler

Sequencing controller for a bank of tri-state bus registers in the memory subsystem. Each register has an active-high `cs` output-disable, a load strobe qualified by `ClockEnable&Tick`, and shares one data bus. Up to `NrOfRequesters` masters issue single-word read/write transactions; this block arbitrates them round-robin and drives per-register `cs`/load lines. It guarantees at most one register drives the bus in any cycle, and always leaves a quiet cycle between bus drivers.

## Interface
Parameters:
- `NrOfRequesters`, 4: number of masters, 2..8.
- `NrOfBits`, 16: data width.
- `NrOfRegs`, 4: registers in the bank, 1..16.
- `AddrBits`, 4: register index width; `2**AddrBits >= NrOfRegs`.

Ports:
- `Clock`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `Tick`  in  1: global advance qualifier; the FSM and pointer change only on edges where `Tick=1`.
- `Req`  in  NrOfRequesters: per-master request; held until `Ack`.
- `ReqWr`  in  NrOfRequesters: 1 = write, 0 = read.
- `ReqAddr`  in  NrOfRequesters*AddrBits: packed register index, master i at `[i*AddrBits +: AddrBits]`.
- `ReqData`  in  NrOfRequesters*NrOfBits: packed write data.
- `BusIn`  in  NrOfBits: shared register output bus.
- `BusOut`  out  NrOfBits: data to all registers' `D`.
- `LoadEn`  out  NrOfRegs: per-register `ClockEnable`.
- `Cs`  out  NrOfRegs: per-register output disable; 1 = Hi-Z.
- `Ack`  out  NrOfRequesters: one-Tick completion pulse.
- `Err`  out  1: valid with `Ack`; address was out of range.
- `RdData`  out  NrOfBits: read result, valid with `Ack`, held until the next read completes.
- `Busy`  out  1: state is not IDLE.

## Operation
- FSM states: IDLE, XFER, ACK.
- **IDLE**
  - On a Tick edge with any `Req` set, pick the winner by round-robin, starting the search at `ptr`.
  - Latch the winner's op, address and data, then go to XFER.
- **XFER, write**
  - `BusOut` = latched data.
  - `LoadEn[addr]` = 1; all `Cs` stay 1.
- **XFER, read**
  - `Cs[addr]` = 0; all other `Cs` = 1.
  - `BusIn` is captured into `RdData` at the Tick edge that leaves XFER.
- **Out of range** (`addr >= NrOfRegs`): no `LoadEn` or `Cs` activity; `Err` = 1 in ACK.
- **ACK**
  - `Ack[winner]` = 1 for this state only.
  - At the exit edge: `ptr` = winner+1 mod `NrOfRequesters`; next state is IDLE.
- A request dropped after latch is ignored; the transaction still completes.
- Outside XFER: `LoadEn` = 0, `Cs` = all ones, and `BusOut` holds its last value.
- `Tick=0` freezes the state and all outputs. Registers ignore held `LoadEn` because their load is also gated by `Tick`.

## Timing
- Reset values: state IDLE, `ptr` 0, `Cs` all ones, `LoadEn` 0, `Ack` 0, `Err` 0, `Busy` 0, `RdData` 0, `BusOut` 0.
- Latency: request sampled at Tick edge E0 → XFER during the following Tick cycle → `Ack` during the Tick cycle after that. One transaction per 3 Tick cycles.
- The register write occurs at the edge ending XFER.
- Bus turnaround: at least 2 Tick cycles (ACK, IDLE) between successive `Cs` low windows.
- Reset asserted mid-XFER: `Cs` goes all ones and `LoadEn` 0 immediately (asynchronous); the transaction is lost and no `Ack` is issued.
- Simultaneous requests: only the winner advances; the others wait. The worst-case wait is `NrOfRequesters`−1 transactions.

## Structure
- Package `ir_bus_pkg`:
  - State encoding constants (IDLE=0, XFER=1, ACK=2).
  - Op encoding (RD=0, WR=1).
  - Packed-field slice helpers.
- Sub-module `rr_arbiter_ir`: combinational round-robin select.
  - Inputs: `Req` and `ptr`.
  - Outputs: one-hot grant and binary index.
- The top module holds the FSM, latches and decoders.

## Test plan
- Write: master 1 writes 0x1234 to reg 2 → `LoadEn`=0100 for exactly one Tick cycle with `BusOut`=0x1234, then `Ack`=0010 with `Err`=0.
- Read: the reg 3 model drives 0xBEEF when `Cs[3]`=0; master 0 reads reg 3 → `Cs`=0111 during XFER only, `RdData`=0xBEEF with `Ack`=0001.
- Fairness: all four `Req` held from reset → acks in order 0,1,2,3,0; never two `Cs` bits low at once; `Cs` all ones for ≥2 cycles between reads.
- Range and Tick: address 9 with `NrOfRegs`=4 → no strobes, `Ack` with `Err`=1. `Tick` low for 5 cycles in XFER → state and outputs frozen, completion delayed by exactly 5 cycles.
- Reset: `Reset` pulsed mid-XFER of a read → `Cs` all ones asynchronously, no `Ack`, `ptr`=0. The next request from master 2 is served normally.

Source files
------------

// File: rtl/ir_bus_pkg.sv
// Shared types and helpers for the tri-state bus register scheduler.
// State/op encodings plus small index helpers for packed per-master fields.
package ir_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // LSB position of field idx in a packed vector of width-bit fields.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    // Modulo-n increment, works for n that is not a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_ir.sv
// Combinational round-robin select: first set request at or after ptr wins.
import ir_bus_pkg::*;

module rr_arbiter_ir #(
    parameter int NrOfRequesters = 4,
    parameter int IdxBits        = 2
) (
    input  logic [NrOfRequesters-1:0] Req,
    input  logic [IdxBits-1:0]        ptr,
    output logic [NrOfRequesters-1:0] grant,
    output logic [IdxBits-1:0]        index,
    output logic                      valid
);

    int                 cand;
    logic [IdxBits-1:0] cand_idx;
    logic               found;

    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NrOfRequesters; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NrOfRequesters) cand = cand - NrOfRequesters;
            cand_idx = IdxBits'(cand);
            if (!found && Req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/ir_bus_scheduler.sv
// Round-robin sequencer for a bank of tri-state bus registers: one driver per
// cycle, with ACK and IDLE cycles forming the turnaround between drivers.
import ir_bus_pkg::*;

module ir_bus_scheduler #(
    parameter int NrOfRequesters = 4,
    parameter int NrOfBits       = 16,
    parameter int NrOfRegs       = 4,
    parameter int AddrBits       = 4
) (
    input  logic                                Clock,
    input  logic                                Reset,
    input  logic                                Tick,
    input  logic [NrOfRequesters-1:0]           Req,
    input  logic [NrOfRequesters-1:0]           ReqWr,
    input  logic [NrOfRequesters*AddrBits-1:0]  ReqAddr,
    input  logic [NrOfRequesters*NrOfBits-1:0]  ReqData,
    input  logic [NrOfBits-1:0]                 BusIn,
    output logic [NrOfBits-1:0]                 BusOut,
    output logic [NrOfRegs-1:0]                 LoadEn,
    output logic [NrOfRegs-1:0]                 Cs,
    output logic [NrOfRequesters-1:0]           Ack,
    output logic                                Err,
    output logic [NrOfBits-1:0]                 RdData,
    output logic                                Busy
);

    localparam int                IdxBits  = $clog2(NrOfRequesters);
    localparam logic [AddrBits:0] RegLimit = (AddrBits+1)'(NrOfRegs);

    state_t                    state;
    logic [IdxBits-1:0]        ptr;
    logic [IdxBits-1:0]        win;
    op_t                       lat_op;
    logic                      lat_oor;

    logic [NrOfRequesters-1:0] gnt;
    logic [IdxBits-1:0]        gnt_idx;
    logic                      gnt_vld;

    logic [AddrBits-1:0]       sel_addr;
    logic [NrOfBits-1:0]       sel_data;
    op_t                       sel_op;
    logic                      sel_oor;
    logic [NrOfRegs-1:0]       sel_dec;
    logic [NrOfRequesters-1:0] win_onehot;

    rr_arbiter_ir #(
        .NrOfRequesters (NrOfRequesters),
        .IdxBits        (IdxBits)
    ) u_arb (
        .Req   (Req),
        .ptr   (ptr),
        .grant (gnt),
        .index (gnt_idx),
        .valid (gnt_vld)
    );

    // Winner's request fields, picked straight off the packed inputs.
    assign sel_addr = ReqAddr[field_lsb(int'(gnt_idx), AddrBits) +: AddrBits];
    assign sel_data = ReqData[field_lsb(int'(gnt_idx), NrOfBits) +: NrOfBits];
    assign sel_op   = op_t'(ReqWr[gnt_idx]);
    assign sel_oor  = ({1'b0, sel_addr} >= RegLimit);

    // Out-of-range addresses decode to all zeros, so no strobe or Cs fires.
    for (genvar r = 0; r < NrOfRegs; r++) begin : g_dec
        assign sel_dec[r] = (sel_addr == AddrBits'(r));
    end

    for (genvar i = 0; i < NrOfRequesters; i++) begin : g_ack
        assign win_onehot[i] = (win == IdxBits'(i));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            lat_op  <= OP_RD;
            lat_oor <= 1'b0;
            BusOut  <= '0;
            LoadEn  <= '0;
            Cs      <= '1;
            Ack     <= '0;
            Err     <= 1'b0;
            RdData  <= '0;
            Busy    <= 1'b0;
        end else if (Tick) begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        state   <= XFER;
                        Busy    <= 1'b1;
                        win     <= gnt_idx;
                        lat_op  <= sel_op;
                        lat_oor <= sel_oor;
                        if (sel_op == OP_WR) begin
                            BusOut <= sel_data;
                            LoadEn <= sel_dec;
                        end else begin
                            Cs <= ~sel_dec;
                        end
                    end
                end
                XFER: begin
                    state  <= ACK;
                    LoadEn <= '0;
                    Cs     <= '1;
                    Ack    <= win_onehot;
                    Err    <= lat_oor;
                    // The register write lands on this same edge via LoadEn&Tick.
                    if (lat_op == OP_RD && !lat_oor) RdData <= BusIn;
                end
                ACK: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Ack   <= '0;
                    Err   <= 1'b0;
                    ptr   <= IdxBits'(wrap_inc(int'(win), NrOfRequesters));
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    LoadEn <= '0;
                    Cs     <= '1;
                    Ack    <= '0;
                    Err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_bus_scheduler.sv
// Directed bench for ir_bus_scheduler with a 4-register bank model on the bus.
module tb_ir_bus_scheduler;

    localparam int NR = 4;
    localparam int NB = 16;
    localparam int NG = 4;
    localparam int AB = 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Tick;
    logic [NR-1:0]     Req;
    logic [NR-1:0]     ReqWr;
    logic [NR*AB-1:0]  ReqAddr;
    logic [NR*NB-1:0]  ReqData;
    logic [NB-1:0]     BusIn;
    logic [NB-1:0]     BusOut;
    logic [NG-1:0]     LoadEn;
    logic [NG-1:0]     Cs;
    logic [NR-1:0]     Ack;
    logic              Err;
    logic [NB-1:0]     RdData;
    logic              Busy;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] regs [NG] = '{16'h1111, 16'h2222, 16'h3333, 16'hBEEF};

    ir_bus_scheduler #(
        .NrOfRequesters (NR),
        .NrOfBits       (NB),
        .NrOfRegs       (NG),
        .AddrBits       (AB)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Tick    (Tick),
        .Req     (Req),
        .ReqWr   (ReqWr),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .BusIn   (BusIn),
        .BusOut  (BusOut),
        .LoadEn  (LoadEn),
        .Cs      (Cs),
        .Ack     (Ack),
        .Err     (Err),
        .RdData  (RdData),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    // Register bank model: drives the bus when its Cs is low, loads on LoadEn&Tick.
    always_comb begin
        BusIn = '0;
        for (int r = 0; r < NG; r++)
            if (!Cs[r]) BusIn = regs[r];
    end

    always @(posedge Clock) begin
        for (int r = 0; r < NG; r++)
            if (Tick && LoadEn[r]) regs[r] <= BusOut;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        chk("single_driver", {31'b0, ($countones(~Cs) <= 1)}, 32'd1);
    endtask

    task automatic set_req(input int m, input logic wr, input logic [AB-1:0] addr,
                           input logic [NB-1:0] data);
        ReqWr[m]          = wr;
        ReqAddr[m*AB+:AB] = addr;
        ReqData[m*NB+:NB] = data;
    endtask

    logic [NR-1:0] exp_ack;
    logic [NG-1:0] exp_cs;
    logic [NB-1:0] exp_rd [5] = '{16'h5A5A, 16'h2222, 16'h1234, 16'hBEEF, 16'h5A5A};
    int            order  [5] = '{0, 1, 2, 3, 0};

    initial begin
        Reset = 1'b1; Tick = 1'b1;
        Req = '0; ReqWr = '0; ReqAddr = '0; ReqData = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_cs", 32'(Cs), 32'hF);
        chk("rst_loaden", 32'(LoadEn), 32'h0);
        chk("rst_ack", 32'(Ack), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_rddata", 32'(RdData), 32'h0);
        chk("rst_busout", 32'(BusOut), 32'h0);
        Reset = 1'b0;

        // Write: master 1 -> reg 2
        set_req(1, 1'b1, 4'd2, 16'h1234); Req = 4'b0010;
        step();
        chk("wr_xfer_loaden", 32'(LoadEn), 32'h4);
        chk("wr_xfer_busout", 32'(BusOut), 32'h1234);
        chk("wr_xfer_cs", 32'(Cs), 32'hF);
        chk("wr_xfer_busy", 32'(Busy), 32'h1);
        chk("wr_xfer_ack", 32'(Ack), 32'h0);
        step();
        chk("wr_ack", 32'(Ack), 32'h2);
        chk("wr_err", 32'(Err), 32'h0);
        chk("wr_ack_loaden", 32'(LoadEn), 32'h0);
        chk("wr_reg2", 32'(regs[2]), 32'h1234);
        Req = '0;
        step();
        chk("wr_idle_ack", 32'(Ack), 32'h0);
        chk("wr_idle_busy", 32'(Busy), 32'h0);

        // Read: master 0 <- reg 3
        set_req(0, 1'b0, 4'd3, 16'h0); Req = 4'b0001;
        step();
        chk("rd_xfer_cs", 32'(Cs), 32'h7);
        chk("rd_xfer_loaden", 32'(LoadEn), 32'h0);
        step();
        chk("rd_ack_cs", 32'(Cs), 32'hF);
        chk("rd_ack", 32'(Ack), 32'h1);
        chk("rd_data", 32'(RdData), 32'hBEEF);
        chk("rd_err", 32'(Err), 32'h0);
        Req = '0;
        step();
        chk("rd_hold", 32'(RdData), 32'hBEEF);

        // Out of range: master 3 writes addr 9
        set_req(3, 1'b1, 4'd9, 16'hCAFE); Req = 4'b1000;
        step();
        chk("oor_loaden", 32'(LoadEn), 32'h0);
        chk("oor_cs", 32'(Cs), 32'hF);
        chk("oor_busy", 32'(Busy), 32'h1);
        step();
        chk("oor_ack", 32'(Ack), 32'h8);
        chk("oor_err", 32'(Err), 32'h1);
        Req = '0;
        step();
        chk("oor_err_clear", 32'(Err), 32'h0);

        // Tick freeze: master 2 reads reg 1, Tick low 5 cycles in XFER
        set_req(2, 1'b0, 4'd1, 16'h0); Req = 4'b0100;
        step();
        chk("frz_xfer_cs", 32'(Cs), 32'hD);
        Tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_cs", 32'(Cs), 32'hD);
            chk("frz_ack", 32'(Ack), 32'h0);
            chk("frz_busy", 32'(Busy), 32'h1);
        end
        Tick = 1'b1;
        step();
        chk("frz_done_ack", 32'(Ack), 32'h4);
        chk("frz_done_rd", 32'(RdData), 32'h2222);
        Req = '0;
        step();

        // Reset mid-XFER of a read by master 1 (ptr is 3, winner 1)
        set_req(1, 1'b0, 4'd0, 16'h0); Req = 4'b0010;
        step();
        chk("rxf_cs", 32'(Cs), 32'hE);
        #2 Reset = 1'b1;
        #1;
        chk("rxf_async_cs", 32'(Cs), 32'hF);
        chk("rxf_async_busy", 32'(Busy), 32'h0);
        chk("rxf_async_loaden", 32'(LoadEn), 32'h0);
        Req = '0;
        @(posedge Clock);
        #1;
        chk("rxf_no_ack", 32'(Ack), 32'h0);
        Reset = 1'b0;
        // ptr back at 0: masters 1 and 3 both request, 1 must win
        set_req(1, 1'b0, 4'd2, 16'h0);
        set_req(3, 1'b0, 4'd2, 16'h0);
        Req = 4'b1010;
        step();
        chk("rxf_ptr_cs", 32'(Cs), 32'hB);
        step();
        chk("rxf_ptr_ack", 32'(Ack), 32'h2);
        chk("rxf_ptr_rd", 32'(RdData), 32'h1234);
        Req = '0;
        step();
        set_req(2, 1'b1, 4'd0, 16'h5A5A); Req = 4'b0100;
        step();
        chk("m2_loaden", 32'(LoadEn), 32'h1);
        chk("m2_busout", 32'(BusOut), 32'h5A5A);
        step();
        chk("m2_ack", 32'(Ack), 32'h4);
        Req = '0;
        step();

        // Fairness: all four requests held from reset, master i reads reg i
        Reset = 1'b1;
        for (int m = 0; m < NR; m++) set_req(m, 1'b0, AB'(m), 16'h0);
        Req = 4'b1111;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_cs  = 4'hF;
            exp_cs[order[k]] = 1'b0;
            exp_ack = '0;
            exp_ack[order[k]] = 1'b1;
            step();
            chk("rr_xfer_cs", 32'(Cs), 32'(exp_cs));
            step();
            chk("rr_ack", 32'(Ack), 32'(exp_ack));
            chk("rr_rd", 32'(RdData), 32'(exp_rd[k]));
            chk("rr_gap1_cs", 32'(Cs), 32'hF);
            step();
            chk("rr_gap2_cs", 32'(Cs), 32'hF);
            chk("rr_idle_ack", 32'(Ack), 32'h0);
        end
        Req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
